txn_engine: RTL and testbench

//  Transaction stage directly downstream of the SIM/face/PIN authentication block.

---
 rtl/txn_engine.sv | 173 +++++++++++++++++
 tb/tb_txn_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txn_engine.sv
// Banking transaction stage behind the authentication block: opens a session on
// a rising access_granted, executes enquiry/withdraw/deposit/logout with limit checks.
module txn_engine #(
    parameter logic [15:0] INIT_BALANCE  = 16'd8000,
    parameter logic [15:0] MAX_TXN       = 16'd5000,
    parameter logic [16:0] SESSION_LIMIT = 17'd12000,
    parameter logic [7:0]  TIMEOUT       = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        access_granted,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_amount,
    output logic        rsp_valid,
    output logic [2:0]  rsp_status,
    output logic [15:0] balance,
    output logic        session_active,
    output logic [7:0]  txn_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SESSION = 2'd1;
    localparam logic [1:0] ST_EXEC    = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [1:0] OP_ENQUIRY  = 2'd0;
    localparam logic [1:0] OP_WITHDRAW = 2'd1;
    localparam logic [1:0] OP_DEPOSIT  = 2'd2;
    localparam logic [1:0] OP_LOGOUT   = 2'd3;

    localparam logic [2:0] STS_OK           = 3'd0;
    localparam logic [2:0] STS_INSUFFICIENT = 3'd1;
    localparam logic [2:0] STS_OVER_TXN     = 3'd2;
    localparam logic [2:0] STS_OVER_SESSION = 3'd3;
    localparam logic [2:0] STS_OVERFLOW     = 3'd4;
    localparam logic [2:0] STS_ZERO_AMT     = 3'd5;

    logic [1:0]  state_q, state_d;
    logic        ag_q, ag_d;
    logic [15:0] balance_q, balance_d;
    logic [16:0] withdrawn_q, withdrawn_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;
    logic [7:0]  txn_count_q, txn_count_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] amount_q, amount_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [2:0]  rsp_status_q, rsp_status_d;

    logic [16:0] withdraw_sum;
    logic [16:0] deposit_sum;
    logic [7:0]  txn_count_inc;

    assign withdraw_sum  = withdrawn_q + {1'b0, amount_q};
    assign deposit_sum   = {1'b0, balance_q} + {1'b0, amount_q};
    assign txn_count_inc = (txn_count_q == 8'hFF) ? txn_count_q : txn_count_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        ag_d         = access_granted;
        balance_d    = balance_q;
        withdrawn_d  = withdrawn_q;
        idle_cnt_d   = idle_cnt_q;
        txn_count_d  = txn_count_q;
        op_d         = op_q;
        amount_d     = amount_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;

        case (state_q)
            ST_IDLE: begin
                if (access_granted && !ag_q) begin
                    state_d     = ST_SESSION;
                    txn_count_d = 8'd0;
                    withdrawn_d = 17'd0;
                    idle_cnt_d  = 8'd0;
                end
            end
            ST_SESSION: begin
                if (req_valid) begin
                    op_d     = req_op;
                    amount_d = req_amount;
                    state_d  = ST_EXEC;
                end else if (!access_granted) begin
                    state_d = ST_IDLE;
                end else if (idle_cnt_q == TIMEOUT - 8'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            ST_EXEC: begin
                // Completes regardless of access_granted so every accepted request gets a response.
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
                rsp_status_d = STS_OK;
                case (op_q)
                    OP_WITHDRAW: begin
                        if (amount_q == 16'd0) begin
                            rsp_status_d = STS_ZERO_AMT;
                        end else if (amount_q > MAX_TXN) begin
                            rsp_status_d = STS_OVER_TXN;
                        end else if (amount_q > balance_q) begin
                            rsp_status_d = STS_INSUFFICIENT;
                        end else if (withdraw_sum > SESSION_LIMIT) begin
                            rsp_status_d = STS_OVER_SESSION;
                        end else begin
                            balance_d   = balance_q - amount_q;
                            withdrawn_d = withdraw_sum;
                            txn_count_d = txn_count_inc;
                        end
                    end
                    OP_DEPOSIT: begin
                        if (amount_q == 16'd0) begin
                            rsp_status_d = STS_ZERO_AMT;
                        end else if (amount_q > MAX_TXN) begin
                            rsp_status_d = STS_OVER_TXN;
                        end else if (deposit_sum[16]) begin
                            rsp_status_d = STS_OVERFLOW;
                        end else begin
                            balance_d   = deposit_sum[15:0];
                            txn_count_d = txn_count_inc;
                        end
                    end
                    default: rsp_status_d = STS_OK;
                endcase
            end
            default: begin
                if (op_q == OP_LOGOUT || !access_granted) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_SESSION;
                    idle_cnt_d = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ag_q         <= 1'b0;
            balance_q    <= INIT_BALANCE;
            withdrawn_q  <= 17'd0;
            idle_cnt_q   <= 8'd0;
            txn_count_q  <= 8'd0;
            op_q         <= OP_ENQUIRY;
            amount_q     <= 16'd0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= STS_OK;
        end else begin
            state_q      <= state_d;
            ag_q         <= ag_d;
            balance_q    <= balance_d;
            withdrawn_q  <= withdrawn_d;
            idle_cnt_q   <= idle_cnt_d;
            txn_count_q  <= txn_count_d;
            op_q         <= op_d;
            amount_q     <= amount_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready      = (state_q == ST_SESSION);
    assign session_active = (state_q != ST_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_status     = rsp_status_q;
    assign balance        = balance_q;
    assign txn_count      = txn_count_q;

endmodule

// File: tb/tb_txn_engine.sv
// Scoreboard bench for txn_engine: a driver pushes model-predicted responses,
// a monitor pops and compares them whenever the engine strobes rsp_valid.
module tb_txn_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        access_granted;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_amount;
    logic        rsp_valid;
    logic [2:0]  rsp_status;
    logic [15:0] balance;
    logic        session_active;
    logic [7:0]  txn_count;

    txn_engine dut (
        .clk            (clk),
        .rst            (rst),
        .access_granted (access_granted),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_amount     (req_amount),
        .rsp_valid      (rsp_valid),
        .rsp_status     (rsp_status),
        .balance        (balance),
        .session_active (session_active),
        .txn_count      (txn_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    status;
        int    bal;
        int    cnt;
        int    accept;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference account: plain integers, rules applied in priority order.
    int m_bal = 8000;
    int m_wd  = 0;
    int m_cnt = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int model_eval(input int op, input int amt);
        int st;
        st = 0;
        if (op == 1) begin
            if (amt == 0)                  st = 5;
            else if (amt > 5000)           st = 2;
            else if (amt > m_bal)          st = 1;
            else if (m_wd + amt > 12000)   st = 3;
            else begin
                m_bal -= amt;
                m_wd  += amt;
                if (m_cnt < 255) m_cnt++;
            end
        end else if (op == 2) begin
            if (amt == 0)                  st = 5;
            else if (amt > 5000)           st = 2;
            else if (m_bal + amt > 65535)  st = 4;
            else begin
                m_bal += amt;
                if (m_cnt < 255) m_cnt++;
            end
        end
        return st;
    endfunction

    task automatic applyStimulus(input int op, input int amt);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        req_valid  = 1'b1;
        req_op     = op[1:0];
        req_amount = amt[15:0];
        e.status   = model_eval(op, amt);
        e.bal      = m_bal;
        e.cnt      = m_cnt;
        e.accept   = cyc;
        e.name     = $sformatf("op%0d_amt%0d", op, amt);
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.name, " status"},  int'(rsp_status), mon_e.status);
                checkOutput({mon_e.name, " balance"}, int'(balance),    mon_e.bal);
                checkOutput({mon_e.name, " count"},   int'(txn_count),  mon_e.cnt);
                checkOutput({mon_e.name, " latency"}, cyc - mon_e.accept, 2);
            end
        end
    end

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        access_granted = 1'b0;
        req_valid      = 1'b0;
        rst            = 1'b0;
        sb.delete();
        m_bal = 8000;
        m_wd  = 0;
        m_cnt = 0;
        #1;
        checkOutput("rst req_ready",      int'(req_ready),      0);
        checkOutput("rst rsp_valid",      int'(rsp_valid),      0);
        checkOutput("rst rsp_status",     int'(rsp_status),     0);
        checkOutput("rst session_active", int'(session_active), 0);
        checkOutput("rst txn_count",      int'(txn_count),      0);
        checkOutput("rst balance",        int'(balance),        8000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic open_session();
        @(negedge clk);
        access_granted = 1'b0;
        @(negedge clk);
        access_granted = 1'b1;
        @(negedge clk);
        checkOutput("open session_active", int'(session_active), 1);
        checkOutput("open req_ready",      int'(req_ready),      1);
        checkOutput("open txn_count",      int'(txn_count),      0);
        m_wd  = 0;
        m_cnt = 0;
    endtask

    function automatic int rand_amount();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return $urandom_range(1, 500);
            2:       return $urandom_range(1, 5000);
            3:       return ($urandom_range(0, 1) == 0) ? 5000 : 5001;
            4:       return $urandom_range(5001, 65535);
            default: return $urandom_range(1, 3000);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst            = 1'b0;
        access_granted = 1'b0;
        req_valid      = 1'b0;
        req_op         = 2'd0;
        req_amount     = 16'd0;

        // First withdraw of a fresh session.
        do_reset();
        open_session();
        applyStimulus(1, 3000);
        wait_drain();

        // Rejections leave the balance untouched.
        do_reset();
        open_session();
        applyStimulus(1, 5001);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(2, 0);
        applyStimulus(2, 5001);
        applyStimulus(1, 8001);

        // Session withdraw cap at exactly 12000.
        applyStimulus(2, 5000);
        applyStimulus(2, 5000);
        applyStimulus(1, 5000);
        applyStimulus(1, 5000);
        applyStimulus(1, 2001);
        applyStimulus(1, 2000);
        applyStimulus(1, 1);

        // Climb to 65000 then probe the deposit overflow edge.
        for (int i = 0; i < 11; i++) applyStimulus(2, 5000);
        applyStimulus(2, 4000);
        applyStimulus(2, 5000);
        applyStimulus(2, 535);
        applyStimulus(2, 1);
        applyStimulus(0, 0);

        // Logout closes the session after its response.
        applyStimulus(3, 0);
        wait_drain();
        @(negedge clk);
        checkOutput("logout session_active", int'(session_active), 0);
        checkOutput("logout keeps balance",  int'(balance),        m_bal);

        // Randomized traffic against the model.
        do_reset();
        open_session();
        for (int i = 0; i < 80; i++) begin
            applyStimulus($urandom_range(0, 2), rand_amount());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();

        // txn_count saturates at 255.
        do_reset();
        open_session();
        for (int i = 0; i < 130; i++) begin
            applyStimulus(2, 1);
            applyStimulus(1, 1);
        end
        wait_drain();
        checkOutput("txn_count saturated", int'(txn_count), m_cnt);

        // Idle timeout after exactly 64 SESSION cycles.
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (session_active && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout cycles", n, 64);
        repeat (5) @(negedge clk);
        checkOutput("held grant no reopen", int'(session_active), 0);
        open_session();

        // Dropping access_granted in SESSION closes it.
        @(negedge clk);
        access_granted = 1'b0;
        @(negedge clk);
        checkOutput("grant drop closes", int'(session_active), 0);

        // Reset during EXEC: no response and the balance reloads.
        open_session();
        applyStimulus(1, 1000);
        wait_drain();
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid  = 1'b1;
        req_op     = 2'd1;
        req_amount = 16'd3000;
        @(posedge clk);
        #1;
        req_valid      = 1'b0;
        access_granted = 1'b0;
        rst            = 1'b0;
        #1;
        checkOutput("exec reset rsp_valid", int'(rsp_valid),      0);
        checkOutput("exec reset balance",   int'(balance),        8000);
        checkOutput("exec reset session",   int'(session_active), 0);
        m_bal = 8000;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);

        checkOutput("scoreboard empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
